// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Sequential packed-BCD to binary converter. One digit per clock, MSD first,
//   using a multiply-by-10-and-add accumulator. Latency is fixed at DIGITS
//   accumulate cycles plus a single-cycle done pulse, whatever the data.
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset (aborts any conversion)
//   start  request a conversion; only looked at while idle
//   bcd    packed BCD, digit DIGITS-1 in the MSBs; captured on the accepting edge
//   busy   high while converting
//   done   one-cycle completion pulse; bin/err are valid from this cycle
//   bin    binary result, held until the next done (0 when err)
//   err    a captured nibble was > 9, held until the next done
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);
  localparam int AW = BIN_W + 4;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_nxt;
  logic [4*DIGITS-1:0] sr;
  logic [CW-1:0]       cnt;
  logic                err_i;
  logic [DIGITS-1:0]   bad;

  // Per-digit range check on the live input; only used on the accepting edge.
  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign bad[g] = (bcd[4*g +: 4] > 4'd9);
  end

  // acc*10 + top nibble; the shifts stay within AW, which has headroom for
  // any valid input. Overflow on invalid digits is harmless: result is forced 0.
  assign acc_nxt = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, sr[4*DIGITS-1 -: 4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sr    <= '0;
      cnt   <= '0;
      err_i <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= bcd;
            acc   <= '0;
            cnt   <= '0;
            err_i <= |bad;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          acc <= acc_nxt;
          sr  <= sr << 4;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DIGITS-1)) begin
            bin   <= err_i ? '0 : acc_nxt[BIN_W-1:0];
            err   <= err_i;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter, the inverse of the team's binary-to-BCD block. It accepts a packed 4-digit BCD word and converts it to a 14-bit unsigned binary value. It works one digit per clock, MSD first, using a multiply-by-10-and-add accumulator. It sits on display/keypad input paths where BCD entry must be turned back into binary for arithmetic. A start/busy/done handshake gives it fixed latency.

## Interface
- DIGITS, 4, number of BCD digits; input width is 4*DIGITS.
- BIN_W, 14, output width; must satisfy 10^DIGITS - 1 < 2^BIN_W (9999 < 16384 at defaults).

- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd  input  4*DIGITS  packed BCD, digit DIGITS-1 in the MSBs; sampled on the accepting edge only.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse; bin/err valid from this cycle.
- bin  output  BIN_W  binary result; held until the next done.
- err  output  1  at least one nibble of the captured bcd was > 9; held until the next done.

## Operation
- States: IDLE, CONV.
- IDLE, start=1: capture bcd into shift register sr, clear acc, cnt<=0, err_i<=(any nibble>9), busy<=1, go to CONV. With start=0, remain in IDLE.
- CONV, each edge: acc<=(acc<<3)+(acc<<1)+sr[top nibble]; sr<=sr<<4; cnt<=cnt+1.
- CONV, edge with cnt==DIGITS-1: apply the final accumulate, then:
  - bin<=err_i ? 0 : final acc;
  - err<=err_i; done<=1; busy<=0; go to IDLE.
- Accumulator is BIN_W+4 bits wide internally. The result is truncated to BIN_W bits, which is lossless for valid input.
- Invalid digits still take the full DIGITS cycles, so latency is data-independent. The result is forced to 0 with err=1.
- start while busy=1 is ignored and not queued. bcd changes during CONV have no effect.
- start asserted in the done cycle is accepted, since the FSM is already in IDLE. This allows back-to-back conversions.
- done is low in every cycle other than the completion pulse.

## Timing
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, bin=0, err=0, acc/sr/cnt=0. Reset overrides start.
- Reset mid-CONV aborts the conversion. No done is produced, and bin/err are cleared to 0.
- Latency: start sampled at edge E0, busy high from E0. Accumulates occur at E1..E_DIGITS. done=1 and busy=0 in the cycle following E_DIGITS (4 cycles after E0 at default).
- Throughput: one conversion per DIGITS+1 cycles (5 at default) with start held or re-pulsed in each done cycle.
- busy and done are never high in the same cycle.

## Test plan
- Reset, then bcd=16'h1345 with start pulsed for 1 cycle. Expect:
  - busy=1 for exactly 4 cycles;
  - done pulses once;
  - bin=14'd1345, err=0.
- Boundary values, each run separately:
  - bcd=16'h9999 -> bin=9999 (14'h270F), err=0;
  - bcd=16'h0000 -> bin=0, err=0;
  - bcd=16'h2345 -> bin=2345.
- Invalid input: bcd=16'h12A4 -> after 4 busy cycles, done=1, err=1, bin=0. A following bcd=16'h0042 -> err=0, bin=42.
- Start while busy: start=1 at E0 with bcd=16'h1111. Then start=1 at E2 with bcd=16'h2222. Expect exactly one done, bin=1111, and no second busy period.
- Back-to-back: hold start=1 continuously, changing bcd in each done cycle (0001, 0010, 0100). Expect done every 5 cycles with bin=1, 10, 100 in order.
- Reset mid-op: start with 16'h9999 and assert rst at E2. Expect busy=0, done=0, bin=0, err=0 next cycle, and no done pulse afterward.
